// File: rtl/uart_autobaud_pkg.sv
// Shared definitions for the UART auto-baud controller: FSM state encoding
// and the constants used to turn a sync-character measurement into a divisor.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_MEASURE,
    ST_CALC,
    ST_LOAD,
    ST_LOCKED
  } state_e;

  // 0x55 in 8N1 has five falling edges spanning exactly eight bit-times
  localparam int SYNC_EDGES = 5;
  // Smallest usable bit period in eighths of a 16x tick (divisor 0, fraction 0)
  localparam int MIN_Q      = 8;
  // Half of 2^SHIFT, so the shift rounds to nearest
  localparam int ROUND_ADD  = 8;
  // T covers 8 bit-times; /16 gives the bit period in eighths of 16x ticks
  localparam int SHIFT      = 4;
  // Largest integer part the 13-bit divisor (stored minus one) can hold
  localparam int MAX_DIV    = 8192;

endpackage

// File: rtl/uart_rx_edge_det.sv
// RX front end: two-flop synchroniser, optional 3-sample majority filter
// (UART_AUTOBAUD_RX_FILTER_EN) and a registered falling-edge pulse.
// Pin-to-pulse latency is 3 cycles, or 4 with the filter enabled.
module uart_rx_edge_det (
  input  logic CLK,
  input  logic RESET,
  input  logic RX,
  output logic FALL
);

  logic sync1_q, sync2_q;
  logic prev_q;
  logic fall_q;
  logic line;

`ifdef UART_AUTOBAUD_RX_FILTER_EN
  logic hist1_q, hist2_q;

  // History taps of the synchronised line feeding the majority vote
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hist1_q <= 1'b1;
      hist2_q <= 1'b1;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end

  // Two of three samples must agree, so a single-cycle glitch never passes
  assign line = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);
`else
  assign line = sync2_q;
`endif

  // Synchronise the pin and register a one-cycle pulse on each high-to-low step
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= RX;
      sync2_q <= sync1_q;
      prev_q  <= line;
      fall_q  <= prev_q & ~line;
    end
  end

  assign FALL = fall_q;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// UART auto-baud controller. Measures a 0x55 sync character on RX, derives
// the divisor and eighth-step fraction and loads them into the baud
// generator with a restart pulse; the host may also load values directly.
// Optional RX glitch filter: define UART_AUTOBAUD_RX_FILTER_EN.
module uart_autobaud_ctrl
  import uart_autobaud_pkg::*;
#(
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd1,
  parameter logic [2:0]  DEFAULT_FRACTION = 3'd0,
  parameter int          CNT_W            = 21
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        RX,
  input  logic        START_DET,
  input  logic        MAN_LOAD,
  input  logic [12:0] MAN_BAUD_VAL,
  input  logic [2:0]  MAN_FRACTION,
  output logic [12:0] BAUD_VAL,
  output logic [2:0]  BAUD_VAL_FRACTION,
  output logic        GEN_RESTART,
  output logic        BUSY,
  output logic        LOCKED,
  output logic        ERR
);

  // Wide enough for T+ROUND_ADD and for comparing against MAX_DIV
  localparam int QW = (CNT_W + 1 > 14) ? CNT_W + 1 : 14;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         edges_q;
  logic [12:0]        baud_q;
  logic [2:0]         frac_q;
  logic               gen_restart_q;
  logic               busy_q;
  logic               locked_q;
  logic               err_q;

  logic               fall;
  logic [QW-1:0]      sum_d;
  logic [QW-1:0]      q_d;
  logic [QW-1:0]      div_d;
  logic               range_ok;
  logic [12:0]        baud_d;
  logic [2:0]         frac_d;

  uart_rx_edge_det u_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .RX    (RX),
    .FALL  (fall)
  );

  // Divisor arithmetic on the frozen count: Q = round(T/16), div = Q/8
  always_comb begin
    sum_d    = QW'(cnt_q) + QW'(ROUND_ADD);
    q_d      = sum_d >> SHIFT;
    div_d    = q_d >> 3;
    range_ok = (q_d >= QW'(MIN_Q)) && (div_d <= QW'(MAX_DIV));
    baud_d   = 13'(div_d - QW'(1));
    frac_d   = q_d[2:0];
  end

  // Control FSM with registered outputs; host load beats a new measurement request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      edges_q       <= '0;
      baud_q        <= DEFAULT_BAUD_VAL;
      frac_q        <= DEFAULT_FRACTION;
      gen_restart_q <= 1'b0;
      busy_q        <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      gen_restart_q <= 1'b0;
      if (MAN_LOAD) begin
        state_q       <= ST_LOCKED;
        cnt_q         <= '0;
        edges_q       <= '0;
        baud_q        <= MAN_BAUD_VAL;
        frac_q        <= MAN_FRACTION;
        gen_restart_q <= 1'b1;
        busy_q        <= 1'b0;
        locked_q      <= 1'b1;
        err_q         <= 1'b0;
      end else if (START_DET) begin
        // Previous divisor stays on the generator until a new one is loaded
        state_q  <= ST_WAIT_START;
        cnt_q    <= '0;
        edges_q  <= '0;
        busy_q   <= 1'b1;
        locked_q <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_WAIT_START: begin
            if (fall) begin
              state_q <= ST_MEASURE;
              cnt_q   <= CNT_W'(1);
              edges_q <= 3'd1;
            end
          end
          ST_MEASURE: begin
            if (fall && (edges_q == 3'(SYNC_EDGES - 1))) begin
              // cnt_q now holds T and is left frozen for the calculation
              state_q <= ST_CALC;
              edges_q <= edges_q + 3'd1;
            end else if (cnt_q == {CNT_W{1'b1}}) begin
              state_q  <= ST_IDLE;
              cnt_q    <= '0;
              edges_q  <= '0;
              baud_q   <= DEFAULT_BAUD_VAL;
              frac_q   <= DEFAULT_FRACTION;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (fall) begin
                edges_q <= edges_q + 3'd1;
              end
            end
          end
          ST_CALC: begin
            if (range_ok) begin
              state_q       <= ST_LOAD;
              baud_q        <= baud_d;
              frac_q        <= frac_d;
              gen_restart_q <= 1'b1;
            end else begin
              state_q  <= ST_IDLE;
              baud_q   <= DEFAULT_BAUD_VAL;
              frac_q   <= DEFAULT_FRACTION;
              busy_q   <= 1'b0;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
            end
            cnt_q   <= '0;
            edges_q <= '0;
          end
          ST_LOAD: begin
            state_q  <= ST_LOCKED;
            busy_q   <= 1'b0;
            locked_q <= 1'b1;
          end
          default: begin
            state_q <= state_q;
          end
        endcase
      end
    end
  end

  assign BAUD_VAL          = baud_q;
  assign BAUD_VAL_FRACTION = frac_q;
  assign GEN_RESTART       = gen_restart_q;
  assign BUSY              = busy_q;
  assign LOCKED            = locked_q;
  assign ERR               = err_q;

endmodule
